// File: rtl/fadd_rr_arbiter.sv
// Packet-level round-robin arbiter sharing one axis_fadd; results return to their issuers via a tag FIFO.
// States: ST_ARB | pick next valid requester after last_grant (1-cycle bubble); ST_ISSUE | stream the granted packet until TLAST.
module fadd_rr_arbiter #(
  parameter int NREQ  = 3,
  parameter int DEPTH = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ*32-1:0]       REQ_A_TDATA,
  input  logic [NREQ*32-1:0]       REQ_B_TDATA,
  input  logic [NREQ-1:0]          REQ_TLAST,
  input  logic [NREQ-1:0]          REQ_TVALID,
  output logic [NREQ-1:0]          REQ_TREADY,
  output logic [31:0]              FADD_A_TDATA,
  output logic [31:0]              FADD_B_TDATA,
  output logic                     FADD_TLAST,
  output logic                     FADD_TVALID,
  input  logic                     FADD_A_TREADY,
  input  logic                     FADD_B_TREADY,
  input  logic [31:0]              FADD_OUT_TDATA,
  input  logic                     FADD_OUT_TLAST,
  input  logic                     FADD_OUT_TVALID,
  output logic                     FADD_OUT_TREADY,
  output logic [31:0]              RSP_TDATA,
  output logic                     RSP_TLAST,
  output logic [NREQ-1:0]          RSP_TVALID,
  input  logic [NREQ-1:0]          RSP_TREADY,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic                     tag_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {ST_ARB, ST_ISSUE} state_t;

  state_t          state, state_nx;
  logic [IDW-1:0]  grant, grant_nx;
  logic [IDW-1:0]  last_grant, last_grant_nx;
  logic [IDW-1:0]  arb_pick, scan_idx;
  logic            arb_found;

  logic [IDW-1:0]  tag_mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            fifo_full, fifo_empty;
  logic            push, pop;
  logic [IDW-1:0]  head;

  logic [31:0]     a_arr [NREQ];
  logic [31:0]     b_arr [NREQ];
  logic [NREQ-1:0] req_tready;
  logic [NREQ-1:0] rsp_tvalid;
  logic            fadd_tvalid;

  always_comb begin
    for (int r = 0; r < NREQ; r++) begin
      a_arr[r] = REQ_A_TDATA[r*32 +: 32];
      b_arr[r] = REQ_B_TDATA[r*32 +: 32];
    end
  end

  // Scan starts one past the previous owner so every requester gets a turn.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = last_grant;
    scan_idx  = last_grant;
    for (int i = 1; i <= NREQ; i++) begin
      scan_idx = IDW'((int'(last_grant) + i) % NREQ);
      if (!arb_found && REQ_TVALID[scan_idx]) begin
        arb_found = 1'b1;
        arb_pick  = scan_idx;
      end
    end
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(DEPTH));

  always_comb begin
    state_nx      = state;
    grant_nx      = grant;
    last_grant_nx = last_grant;
    req_tready    = '0;
    fadd_tvalid   = 1'b0;
    push          = 1'b0;
    case (state)
      ST_ARB: begin
        if (arb_found) begin
          grant_nx = arb_pick;
          state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        fadd_tvalid       = REQ_TVALID[grant] & ~fifo_full;
        req_tready[grant] = FADD_A_TREADY & FADD_B_TREADY & ~fifo_full;
        push              = REQ_TVALID[grant] & FADD_A_TREADY & FADD_B_TREADY & ~fifo_full;
        if (push && REQ_TLAST[grant]) begin
          last_grant_nx = grant;
          state_nx      = ST_ARB;
        end
      end
      default: state_nx = ST_ARB;
    endcase
  end

  assign REQ_TREADY   = req_tready;
  assign FADD_TVALID  = fadd_tvalid;
  assign FADD_A_TDATA = a_arr[grant];
  assign FADD_B_TDATA = b_arr[grant];
  assign FADD_TLAST   = REQ_TLAST[grant];

  // Result side is steered only by the oldest outstanding tag.
  assign head = tag_mem[rd_ptr];

  always_comb begin
    rsp_tvalid       = '0;
    rsp_tvalid[head] = FADD_OUT_TVALID & ~fifo_empty;
  end

  assign RSP_TVALID      = rsp_tvalid;
  assign RSP_TDATA       = FADD_OUT_TDATA;
  assign RSP_TLAST       = FADD_OUT_TLAST;
  assign FADD_OUT_TREADY = RSP_TREADY[head] & ~fifo_empty;
  assign pop             = FADD_OUT_TVALID & FADD_OUT_TREADY;
  assign inflight        = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ARB;
      grant      <= '0;
      last_grant <= IDW'(NREQ - 1);
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      tag_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      last_grant <= last_grant_nx;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (FADD_OUT_TVALID && fifo_empty) tag_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant;
  end

endmodule

// File: tb/tb_fadd_rr_arbiter.sv
// Bench for fadd_rr_arbiter: cycle table, directed corner sequences and random traffic against a queue-based model.
module tb_fadd_rr_arbiter;
  localparam int NREQ  = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NREQ*32-1:0] REQ_A_TDATA, REQ_B_TDATA;
  logic [NREQ-1:0]    REQ_TLAST, REQ_TVALID, REQ_TREADY;
  logic [31:0]        FADD_A_TDATA, FADD_B_TDATA;
  logic               FADD_TLAST, FADD_TVALID, FADD_A_TREADY, FADD_B_TREADY;
  logic [31:0]        FADD_OUT_TDATA;
  logic               FADD_OUT_TLAST, FADD_OUT_TVALID, FADD_OUT_TREADY;
  logic [31:0]        RSP_TDATA;
  logic               RSP_TLAST;
  logic [NREQ-1:0]    RSP_TVALID, RSP_TREADY;
  logic [3:0]         inflight;
  logic               tag_err;

  fadd_rr_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .REQ_A_TDATA(REQ_A_TDATA), .REQ_B_TDATA(REQ_B_TDATA), .REQ_TLAST(REQ_TLAST),
    .REQ_TVALID(REQ_TVALID), .REQ_TREADY(REQ_TREADY),
    .FADD_A_TDATA(FADD_A_TDATA), .FADD_B_TDATA(FADD_B_TDATA), .FADD_TLAST(FADD_TLAST),
    .FADD_TVALID(FADD_TVALID), .FADD_A_TREADY(FADD_A_TREADY), .FADD_B_TREADY(FADD_B_TREADY),
    .FADD_OUT_TDATA(FADD_OUT_TDATA), .FADD_OUT_TLAST(FADD_OUT_TLAST),
    .FADD_OUT_TVALID(FADD_OUT_TVALID), .FADD_OUT_TREADY(FADD_OUT_TREADY),
    .RSP_TDATA(RSP_TDATA), .RSP_TLAST(RSP_TLAST), .RSP_TVALID(RSP_TVALID), .RSP_TREADY(RSP_TREADY),
    .inflight(inflight), .tag_err(tag_err)
  );

  typedef struct { logic [31:0] a; logic [31:0] b; logic last; } beat_t;
  typedef struct { logic [31:0] d; logic last; int t; } res_t;
  typedef struct {
    logic v; logic l; logic [31:0] a; logic [31:0] b;
    logic ov; logic [31:0] od; logic ol;
    logic [2:0] etr; logic efv; logic [2:0] erv; logic [3:0] einf;
  } vec_t;

  beat_t       pend [NREQ][$];
  logic [31:0] exp_rsp [NREQ][$];
  res_t        pipe[$];
  int          tagq[$];
  int          issue_log[$];
  int          owner, last_owner;
  logic        tag_err_m;
  logic [NREQ-1:0] vgate, rrdy;
  logic        ardy, brdy, oen;
  int          lat_min, lat_max;
  int          cyc, overlap;
  int          checks = 0, errors = 0;
  vec_t        vecs [7];

  // Exact conversions for small positive integers held as binary32.
  function automatic int unsigned f2i(input logic [31:0] f);
    int e;
    logic [23:0] m;
    e = int'(f[30:23]) - 127;
    m = {1'b1, f[22:0]};
    return int'(m) >> (23 - e);
  endfunction

  function automatic logic [31:0] i2f(input int unsigned v);
    int p;
    logic [31:0] r;
    p = 0;
    for (int i = 0; i < 32; i++) if (v[i]) p = i;
    r[31]    = 1'b0;
    r[30:23] = 8'(p + 127);
    r[22:0]  = 23'(v << (23 - p));
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic add_packet(input int r, input int n, input int base);
    beat_t bt;
    for (int i = 0; i < n; i++) begin
      bt.a = i2f(base + i);
      bt.b = i2f(base + i + 1);
      bt.last = (i == n - 1);
      pend[r].push_back(bt);
    end
  endtask

  task automatic add_rand_packet(input int r);
    beat_t bt;
    int n;
    n = int'($urandom_range(5, 1));
    for (int i = 0; i < n; i++) begin
      bt.a = i2f($urandom_range(1000, 1));
      bt.b = i2f($urandom_range(1000, 1));
      bt.last = (i == n - 1);
      pend[r].push_back(bt);
    end
  endtask

  task automatic drive_idle();
    REQ_TVALID = '0; REQ_TLAST = '0; REQ_A_TDATA = '0; REQ_B_TDATA = '0;
    FADD_OUT_TVALID = 1'b0; FADD_OUT_TDATA = '0; FADD_OUT_TLAST = 1'b0;
    FADD_A_TREADY = 1'b1; FADD_B_TREADY = 1'b1; RSP_TREADY = '1;
  endtask

  task automatic do_reset(input bit flush_pipe);
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_req_tready", REQ_TREADY, 0);
    check("rst_fadd_tvalid", FADD_TVALID, 0);
    check("rst_out_tready", FADD_OUT_TREADY, 0);
    check("rst_rsp_tvalid", RSP_TVALID, 0);
    check("rst_inflight", inflight, 0);
    check("rst_tag_err", tag_err, 0);
    owner = -1; last_owner = NREQ - 1; tag_err_m = 1'b0;
    tagq.delete(); issue_log.delete();
    for (int r = 0; r < NREQ; r++) begin pend[r].delete(); exp_rsp[r].delete(); end
    if (flush_pipe) pipe.delete();
  endtask

  // One clock of traffic: drive, compare against the model, then advance the model.
  task automatic run_cycle();
    logic [NREQ-1:0] v, exp_tr, exp_rv;
    logic exp_fv, exp_otr, ihs, ohs, found;
    int head, t, c;
    beat_t bt;
    logic [31:0] sum;
    @(negedge clk);
    cyc++;
    for (int r = 0; r < NREQ; r++) begin
      v[r] = (pend[r].size() > 0) && vgate[r];
      REQ_A_TDATA[r*32 +: 32] = (pend[r].size() > 0) ? pend[r][0].a : 32'h0;
      REQ_B_TDATA[r*32 +: 32] = (pend[r].size() > 0) ? pend[r][0].b : 32'h0;
      REQ_TLAST[r] = (pend[r].size() > 0) ? pend[r][0].last : 1'b0;
    end
    REQ_TVALID = v;
    FADD_A_TREADY = ardy; FADD_B_TREADY = brdy; RSP_TREADY = rrdy;
    FADD_OUT_TVALID = (pipe.size() > 0) && (pipe[0].t <= cyc) && oen;
    FADD_OUT_TDATA  = (pipe.size() > 0) ? pipe[0].d : 32'h0;
    FADD_OUT_TLAST  = (pipe.size() > 0) ? pipe[0].last : 1'b0;
    #1;
    exp_tr = '0; exp_fv = 1'b0; ihs = 1'b0;
    if (owner >= 0) begin
      exp_fv = v[owner] && (tagq.size() < DEPTH);
      if (ardy && brdy && tagq.size() < DEPTH) exp_tr = NREQ'(1) << owner;
      ihs = exp_fv && ardy && brdy;
    end
    exp_rv = '0; exp_otr = 1'b0;
    head = (tagq.size() > 0) ? tagq[0] : -1;
    if (head >= 0) begin
      exp_otr = rrdy[head];
      if (FADD_OUT_TVALID) exp_rv = NREQ'(1) << head;
    end
    ohs = FADD_OUT_TVALID && exp_otr;
    check("req_tready", REQ_TREADY, exp_tr);
    check("fadd_tvalid", FADD_TVALID, exp_fv);
    check("out_tready", FADD_OUT_TREADY, exp_otr);
    check("rsp_tvalid", RSP_TVALID, exp_rv);
    check("inflight", inflight, tagq.size());
    check("tag_err", tag_err, tag_err_m);
    if (exp_fv) begin
      check("fadd_a", FADD_A_TDATA, pend[owner][0].a);
      check("fadd_b", FADD_B_TDATA, pend[owner][0].b);
      check("fadd_tlast", FADD_TLAST, pend[owner][0].last);
    end
    if (ohs) begin
      check("rsp_tdata", RSP_TDATA, exp_rsp[head][0]);
      check("rsp_tlast", RSP_TLAST, pipe[0].last);
    end
    if (FADD_OUT_TVALID && head < 0) tag_err_m = 1'b1;
    if (ohs) begin
      pipe.pop_front();
      void'(tagq.pop_front());
      void'(exp_rsp[head].pop_front());
    end
    if (ihs) begin
      bt = pend[owner].pop_front();
      sum = i2f(f2i(bt.a) + f2i(bt.b));
      t = cyc + int'($urandom_range(lat_max, lat_min));
      if (pipe.size() > 0 && t < pipe[$].t) t = pipe[$].t;
      pipe.push_back('{sum, bt.last, t});
      tagq.push_back(owner);
      exp_rsp[owner].push_back(sum);
      issue_log.push_back(owner);
      if (ohs) overlap++;
      if (bt.last) begin last_owner = owner; owner = -1; end
    end else if (owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
        c = (last_owner + k) % NREQ;
        if (!found && v[c]) begin owner = c; found = 1'b1; end
      end
    end
  endtask

  task automatic wait_idle(input int bound);
    int n;
    logic busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < bound) begin
      run_cycle();
      n++;
      busy = (tagq.size() > 0);
      for (int r = 0; r < NREQ; r++) if (pend[r].size() > 0) busy = 1'b1;
    end
    check("drain_within_bound", busy, 0);
  endtask

  initial begin
    int exp_order [8];
    rst = 1'b1; cyc = 0; overlap = 0;
    vgate = '1; rrdy = '1; ardy = 1'b1; brdy = 1'b1; oen = 1'b1;
    lat_min = 1; lat_max = 1;
    drive_idle();
    do_reset(1'b1);

    // r1 streams 1+2 .. 4+5; bench plays a 1-cycle fadd by hand.
    vecs[0] = '{1'b1, 1'b0, 32'h3F800000, 32'h40000000, 1'b0, 32'h0,        1'b0, 3'b000, 1'b0, 3'b000, 4'd0};
    vecs[1] = '{1'b1, 1'b0, 32'h3F800000, 32'h40000000, 1'b0, 32'h0,        1'b0, 3'b010, 1'b1, 3'b000, 4'd0};
    vecs[2] = '{1'b1, 1'b0, 32'h40000000, 32'h40400000, 1'b1, 32'h40400000, 1'b0, 3'b010, 1'b1, 3'b010, 4'd1};
    vecs[3] = '{1'b1, 1'b0, 32'h40400000, 32'h40800000, 1'b1, 32'h40A00000, 1'b0, 3'b010, 1'b1, 3'b010, 4'd1};
    vecs[4] = '{1'b1, 1'b1, 32'h40800000, 32'h40A00000, 1'b1, 32'h40E00000, 1'b0, 3'b010, 1'b1, 3'b010, 4'd1};
    vecs[5] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 32'h41100000, 1'b1, 3'b000, 1'b0, 3'b010, 4'd1};
    vecs[6] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 3'b000, 1'b0, 3'b000, 4'd0};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      cyc++;
      REQ_TVALID = {1'b0, vecs[i].v, 1'b0};
      REQ_TLAST  = {1'b0, vecs[i].l, 1'b0};
      REQ_A_TDATA = '0; REQ_A_TDATA[63:32] = vecs[i].a;
      REQ_B_TDATA = '0; REQ_B_TDATA[63:32] = vecs[i].b;
      FADD_OUT_TVALID = vecs[i].ov; FADD_OUT_TDATA = vecs[i].od; FADD_OUT_TLAST = vecs[i].ol;
      #1;
      check("tbl_req_tready", REQ_TREADY, vecs[i].etr);
      check("tbl_fadd_tvalid", FADD_TVALID, vecs[i].efv);
      check("tbl_rsp_tvalid", RSP_TVALID, vecs[i].erv);
      check("tbl_inflight", inflight, vecs[i].einf);
      if (vecs[i].efv) begin
        check("tbl_fadd_a", FADD_A_TDATA, vecs[i].a);
        check("tbl_fadd_tlast", FADD_TLAST, vecs[i].l);
      end
      if (vecs[i].ov) begin
        check("tbl_rsp_tdata", RSP_TDATA, vecs[i].od);
        check("tbl_rsp_tlast", RSP_TLAST, vecs[i].ol);
      end
    end

    // Round-robin: all three valid from reset, 2-beat packets, r0 has a second packet.
    do_reset(1'b1);
    lat_min = 2; lat_max = 2;
    add_packet(0, 2, 10); add_packet(0, 2, 20); add_packet(1, 2, 30); add_packet(2, 2, 40);
    wait_idle(200);
    exp_order = '{0, 0, 1, 1, 2, 2, 0, 0};
    check("rr_issue_count", issue_log.size(), 8);
    for (int i = 0; i < 8 && i < issue_log.size(); i++) check("rr_order", issue_log[i], exp_order[i]);

    // Backpressure until the tag FIFO is full, then release.
    do_reset(1'b1);
    lat_min = 1; lat_max = 1; rrdy = 3'b110;
    add_packet(0, 12, 100);
    repeat (14) run_cycle();
    check("bp_inflight_full", inflight, 8);
    check("bp_req_tready", REQ_TREADY, 0);
    check("bp_fadd_tvalid", FADD_TVALID, 0);
    rrdy = '1; overlap = 0;
    wait_idle(100);
    check("bp_push_pop_overlap", (overlap > 0), 1);

    // fadd stall mid-packet.
    do_reset(1'b1);
    lat_min = 3; lat_max = 3;
    add_packet(2, 8, 200);
    repeat (4) run_cycle();
    ardy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_cycle();
      check("stall_tvalid", FADD_TVALID, 1);
      check("stall_tready", REQ_TREADY, 0);
      check("stall_a_stable", FADD_A_TDATA, i2f(203));
    end
    ardy = 1'b1;
    wait_idle(100);

    // Reset after 2 of 4 beats, leaving stale results inside the fake fadd.
    do_reset(1'b1);
    lat_min = 30; lat_max = 30;
    add_packet(0, 4, 300);
    repeat (3) run_cycle();
    do_reset(1'b0);
    repeat (40) run_cycle();
    check("spur_tag_err", tag_err, 1);
    check("spur_inflight", inflight, 0);
    check("spur_out_tready", FADD_OUT_TREADY, 0);
    do_reset(1'b1);

    // Random traffic.
    lat_min = 1; lat_max = 4;
    for (int n = 0; n < 2000; n++) begin
      vgate = NREQ'($urandom) | NREQ'($urandom);
      rrdy  = NREQ'($urandom) | NREQ'($urandom);
      ardy  = ($urandom_range(9, 0) != 0);
      brdy  = ($urandom_range(9, 0) != 0);
      oen   = ($urandom_range(4, 0) != 0);
      for (int r = 0; r < NREQ; r++)
        if (pend[r].size() == 0 && $urandom_range(3, 0) == 0) add_rand_packet(r);
      run_cycle();
    end
    vgate = '1; rrdy = '1; ardy = 1'b1; brdy = 1'b1; oen = 1'b1;
    wait_idle(500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
